// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// PS/2 host-to-device transmitter: inhibits the bus, shifts one odd-parity
// framed byte out under device clocking and checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_REL
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [1:0]       r_clkSync;
  logic [1:0]       r_dataSync;
  logic             r_clkPrev;
  logic [INH_W-1:0] r_inhCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic [3:0]       r_bitIdx;
  logic [7:0]       r_data;
  logic             r_parity;
  logic             r_dataOe;

  logic w_clkLine;
  logic w_dataLine;
  logic w_clkFall;
  logic w_timerOn;
  logic w_timeout;
  logic w_inhDone;
  logic w_lastBit;

  assign w_clkLine  = r_clkSync[1];
  assign w_dataLine = r_dataSync[1];
  assign w_clkFall  = r_clkPrev & ~w_clkLine;
  assign w_timerOn  = (r_state == SEND) || (r_state == ACK) || (r_state == WAIT_REL);
  assign w_timeout  = w_timerOn && (r_toCnt == TO_LAST);
  assign w_inhDone  = (r_inhCnt == INH_LAST);
  assign w_lastBit  = (r_bitIdx == 4'd9);

  // Both bus lines are asynchronous; idle level of the bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk_in};
      r_dataSync <= {r_dataSync[0], ps2_data_in};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_nextState = INHIBIT;
        end
      end
      INHIBIT: begin
        if (w_inhDone) begin
          w_nextState = START;
        end
      end
      START: begin
        w_nextState = SEND;
      end
      SEND: begin
        if (w_timeout) begin
          w_nextState = IDLE;
        end else if (w_clkFall && w_lastBit) begin
          w_nextState = ACK;
        end
      end
      ACK: begin
        if (w_timeout) begin
          w_nextState = IDLE;
        end else if (w_clkFall) begin
          w_nextState = w_dataLine ? IDLE : WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (w_timeout || (w_clkLine && w_dataLine)) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // done/err are decoded from the final state so busy still covers the pulse.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    err         = w_timeout;
    case (r_state)
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
      end
      START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      SEND: begin
        ps2_data_oe = r_dataOe;
      end
      ACK: begin
        if (!w_timeout && w_clkFall && w_dataLine) begin
          err = 1'b1;
        end
      end
      WAIT_REL: begin
        done = !w_timeout && w_clkLine && w_dataLine;
      end
      default: begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
      end
    endcase
  end

  // Frame datapath: the host changes data on each device falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inhCnt <= '0;
      r_toCnt  <= '0;
      r_bitIdx <= 4'd0;
      r_data   <= 8'h00;
      r_parity <= 1'b0;
      r_dataOe <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_start) begin
            r_data   <= tx_data;
            r_parity <= ~^tx_data;
            r_inhCnt <= '0;
          end
        end
        INHIBIT: begin
          if (!w_inhDone) begin
            r_inhCnt <= r_inhCnt + 1'b1;
          end
        end
        START: begin
          r_toCnt  <= '0;
          r_bitIdx <= 4'd0;
          r_dataOe <= 1'b1;
        end
        SEND, ACK, WAIT_REL: begin
          if (!w_timeout) begin
            r_toCnt <= r_toCnt + 1'b1;
          end
          if ((r_state == SEND) && w_clkFall && !w_timeout) begin
            r_bitIdx <= r_bitIdx + 4'd1;
            if (r_bitIdx < 4'd8) begin
              r_dataOe <= ~r_data[r_bitIdx[2:0]];
            end else if (r_bitIdx == 4'd8) begin
              r_dataOe <= ~r_parity;
            end else begin
              r_dataOe <= 1'b0;
            end
          end
        end
        default: begin
          r_dataOe <= 1'b0;
        end
      endcase
    end
  end

endmodule
